// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl - multi-cycle MIPS control FSM.
//
// Sequences one instruction over 2-5 cycles through the shared ALU, the
// single memory port and the register file. It drives every datapath mux
// select and write enable, and it stalls in IF, MRD and MWR until MIO_ready.
//
// Ports
//   clk, reset            : clock; synchronous active-high reset to IF
//   opcode, funct         : IR[31:26], IR[5:0] (stable from ID onward)
//   zero                  : ALU zero flag (the branch decision is made in the
//                           datapath from PCWriteCond/Branch_bne)
//   MIO_ready             : memory/IO access completes this cycle
//   PCWrite, PCWriteCond, Branch_bne, IorD, MemRead, MemWrite, IRWrite,
//   RegWrite, CPU_MIO, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUop
//                         : datapath controls
//   state                 : current state code, for debug
// ---------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       Branch_bne,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       CPU_MIO,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUop,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_LWB   = 4'd4,
        S_MWR   = 4'd5,
        S_EXR   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_J     = 4'd9,
        S_EXI   = 4'd10,
        S_IWB   = 4'd11,
        S_JAL   = 4'd12
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t r_state;
    state_t w_state_next;

    // The branch condition is resolved in the datapath; the flag is only
    // part of this block's port list for top-level wiring.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IF;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        Branch_bne   = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        CPU_MIO      = 1'b0;
        RegDst       = 2'b00;
        MemtoReg     = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSource     = 2'b00;
        ALUop        = 3'b000;
        state        = r_state;

        case (r_state)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                ALUop   = OP_ADD;
                // PC+4 and the IR are only captured once the fetch lands.
                PCWrite = MIO_ready;
                IRWrite = MIO_ready;
                w_state_next = MIO_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ALUSrcB = 2'b11;
                ALUop   = OP_ADD;
                case (opcode)
                    6'b000000:            w_state_next = S_EXR;
                    6'b100011, 6'b101011: w_state_next = S_MADDR;
                    6'b000100, 6'b000101: w_state_next = S_BR;
                    6'b000010:            w_state_next = S_J;
                    6'b000011:            w_state_next = S_JAL;
                    6'b001000, 6'b001100,
                    6'b001101, 6'b001010: w_state_next = S_EXI;
                    default:              w_state_next = S_IF;
                endcase
            end
            S_MADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = OP_ADD;
                w_state_next = (opcode == 6'b100011) ? S_MRD : S_MWR;
            end
            S_MRD: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                IorD    = 1'b1;
                w_state_next = MIO_ready ? S_LWB : S_MRD;
            end
            S_LWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
                IorD     = 1'b1;
                w_state_next = MIO_ready ? S_IF : S_MWR;
            end
            S_EXR: begin
                ALUSrcA = 1'b1;
                case (funct)
                    6'b100010: ALUop = OP_SUB;
                    6'b100100: ALUop = OP_AND;
                    6'b100101: ALUop = OP_OR;
                    6'b101010: ALUop = OP_SLT;
                    6'b100111: ALUop = OP_NOR;
                    6'b100110: ALUop = OP_XOR;
                    6'b000010: ALUop = OP_SRL;
                    default:   ALUop = OP_ADD;
                endcase
                w_state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUop       = OP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                Branch_bne  = (opcode == 6'b000101);
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                // PC is already PC+4 here, so the link register gets the
                // return address directly from the PC mux input.
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            S_EXI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    6'b001100: ALUop = OP_AND;
                    6'b001101: ALUop = OP_OR;
                    6'b001010: ALUop = OP_SLT;
                    default:   ALUop = OP_ADD;
                endcase
                w_state_next = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            default: begin
                w_state_next = S_IF;
            end
        endcase

        // Reset silences the bus and every enable immediately, so an access
        // in flight is dropped in the same cycle reset is seen.
        if (reset) begin
            w_state_next = S_IF;
            PCWrite      = 1'b0;
            PCWriteCond  = 1'b0;
            Branch_bne   = 1'b0;
            IorD         = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            RegWrite     = 1'b0;
            CPU_MIO      = 1'b0;
            RegDst       = 2'b00;
            MemtoReg     = 2'b00;
            ALUSrcA      = 1'b0;
            ALUSrcB      = 2'b00;
            PCSource     = 2'b00;
            ALUop        = 3'b000;
            state        = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl - scoreboard bench for mc_ctrl.
// Each stimulus step drives one cycle of inputs and queues the hand-derived
// output bundle for that cycle; a monitor on the falling edge pops and
// compares the whole bundle.
// Bundle layout (25 bits): state[4], PCWrite, PCWriteCond, Branch_bne, IorD,
// MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO, RegDst[2], MemtoReg[2],
// ALUSrcA, ALUSrcB[2], PCSource[2], ALUop[3]
// ---------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       MIO_ready = 1'b0;
    logic       PCWrite, PCWriteCond, Branch_bne, IorD, MemRead, MemWrite;
    logic       IRWrite, RegWrite, CPU_MIO, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUop;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .MIO_ready(MIO_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch_bne(Branch_bne),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .CPU_MIO(CPU_MIO),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUop(ALUop), .state(state)
    );

    always #5 clk = ~clk;

    // Hand-derived output bundles, one per state flavour.
    //                          st     PW PWC BNE IoD MR MW IRW RW CPU RD    M2R   ASA ASB   PCS   ALUop
    localparam logic [24:0] E_RST   = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b0,2'b00,2'b00,3'b000};
    localparam logic [24:0] E_IFW   = {4'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,1'b0,2'b01,2'b00,3'b010};
    localparam logic [24:0] E_IFR   = {4'd0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1, 2'b00,2'b00,1'b0,2'b01,2'b00,3'b010};
    localparam logic [24:0] E_ID    = {4'd1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b0,2'b11,2'b00,3'b010};
    localparam logic [24:0] E_MADDR = {4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b10,2'b00,3'b010};
    localparam logic [24:0] E_MRD   = {4'd3, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,1'b0,2'b00,2'b00,3'b000};
    localparam logic [24:0] E_LWB   = {4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b01,1'b0,2'b00,2'b00,3'b000};
    localparam logic [24:0] E_MWR   = {4'd5, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 2'b00,2'b00,1'b0,2'b00,2'b00,3'b000};
    localparam logic [24:0] E_EXADD = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b00,3'b010};
    localparam logic [24:0] E_EXSUB = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b00,3'b110};
    localparam logic [24:0] E_EXSRL = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b00,3'b101};
    localparam logic [24:0] E_EXNOR = {4'd6, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b00,3'b100};
    localparam logic [24:0] E_RWB   = {4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b01,2'b00,1'b0,2'b00,2'b00,3'b000};
    localparam logic [24:0] E_BNE   = {4'd8, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b01,3'b110};
    localparam logic [24:0] E_BEQ   = {4'd8, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b00,2'b01,3'b110};
    localparam logic [24:0] E_J     = {4'd9, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b0,2'b00,2'b10,3'b000};
    localparam logic [24:0] E_JAL   = {4'd12,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b10,2'b10,1'b0,2'b00,2'b10,3'b000};
    localparam logic [24:0] E_EIADD = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b10,2'b00,3'b010};
    localparam logic [24:0] E_EIAND = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b10,2'b00,3'b000};
    localparam logic [24:0] E_EIOR  = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b10,2'b00,3'b001};
    localparam logic [24:0] E_EISLT = {4'd10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,2'b10,2'b00,3'b111};
    localparam logic [24:0] E_IWB   = {4'd11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'b00,2'b00,1'b0,2'b00,2'b00,3'b000};

    logic [24:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    wire [24:0] w_act = {state, PCWrite, PCWriteCond, Branch_bne, IorD,
                         MemRead, MemWrite, IRWrite, RegWrite, CPU_MIO,
                         RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUop};

    // Monitor: the DUT presents a control bundle every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [24:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (w_act !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                         n, w_act, e, w_act[24:21], e[24:21]);
            end else begin
                $display("ok   %s: bundle %h", n, w_act);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue expectation.
    task automatic step(input string n, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input logic [24:0] e);
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        funct     = fn;
        zero      = z;
        MIO_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    initial begin
        // reset
        step("rst0", 1, 6'h00, 6'h00, 0, 1, E_RST);
        step("rst1", 1, 6'h00, 6'h00, 0, 1, E_RST);
        // add $3,$1,$2 (0x00221820): opcode 0, funct 100000
        step("add_if",  0, 6'b000000, 6'b100000, 0, 1, E_IFR);
        step("add_id",  0, 6'b000000, 6'b100000, 0, 1, E_ID);
        step("add_exr", 0, 6'b000000, 6'b100000, 0, 1, E_EXADD);
        step("add_rwb", 0, 6'b000000, 6'b100000, 0, 1, E_RWB);
        // lw with 3 wait cycles in MRD, plus a fetch wait in front
        step("lw_ifw",  0, 6'b100011, 6'b000000, 0, 0, E_IFW);
        step("lw_if",   0, 6'b100011, 6'b000000, 0, 1, E_IFR);
        step("lw_id",   0, 6'b100011, 6'b000000, 0, 1, E_ID);
        step("lw_madr", 0, 6'b100011, 6'b000000, 0, 1, E_MADDR);
        step("lw_mrw1", 0, 6'b100011, 6'b000000, 0, 0, E_MRD);
        step("lw_mrw2", 0, 6'b100011, 6'b000000, 0, 0, E_MRD);
        step("lw_mrw3", 0, 6'b100011, 6'b000000, 0, 0, E_MRD);
        step("lw_mrd",  0, 6'b100011, 6'b000000, 0, 1, E_MRD);
        step("lw_lwb",  0, 6'b100011, 6'b000000, 0, 1, E_LWB);
        // bne zero=1, beq zero=1
        step("bne_if",  0, 6'b000101, 6'b000000, 1, 1, E_IFR);
        step("bne_id",  0, 6'b000101, 6'b000000, 1, 1, E_ID);
        step("bne_br",  0, 6'b000101, 6'b000000, 1, 1, E_BNE);
        step("beq_if",  0, 6'b000100, 6'b000000, 1, 1, E_IFR);
        step("beq_id",  0, 6'b000100, 6'b000000, 1, 1, E_ID);
        step("beq_br",  0, 6'b000100, 6'b000000, 1, 1, E_BEQ);
        // jal, j
        step("jal_if",  0, 6'b000011, 6'b000000, 0, 1, E_IFR);
        step("jal_id",  0, 6'b000011, 6'b000000, 0, 1, E_ID);
        step("jal_jal", 0, 6'b000011, 6'b000000, 0, 1, E_JAL);
        step("j_if",    0, 6'b000010, 6'b000000, 0, 1, E_IFR);
        step("j_id",    0, 6'b000010, 6'b000000, 0, 1, E_ID);
        step("j_j",     0, 6'b000010, 6'b000000, 0, 1, E_J);
        // sw, reset on second MWR wait cycle
        step("sw_if",   0, 6'b101011, 6'b000000, 0, 1, E_IFR);
        step("sw_id",   0, 6'b101011, 6'b000000, 0, 1, E_ID);
        step("sw_madr", 0, 6'b101011, 6'b000000, 0, 1, E_MADDR);
        step("sw_mww1", 0, 6'b101011, 6'b000000, 0, 0, E_MWR);
        step("sw_rst",  1, 6'b101011, 6'b000000, 0, 0, E_RST);
        step("sw_after",0, 6'b101011, 6'b000000, 0, 0, E_IFW);
        step("sw_if2",  0, 6'b101011, 6'b000000, 0, 1, E_IFR);
        step("sw_id2",  0, 6'b101011, 6'b000000, 0, 1, E_ID);
        step("sw_madr2",0, 6'b101011, 6'b000000, 0, 1, E_MADDR);
        step("sw_mwr",  0, 6'b101011, 6'b000000, 0, 1, E_MWR);
        // unknown opcode is a 2-cycle nop
        step("nop_if",  0, 6'b111111, 6'b000000, 0, 1, E_IFR);
        step("nop_id",  0, 6'b111111, 6'b000000, 0, 1, E_ID);
        // srl, sub, nor, unknown funct
        step("srl_if",  0, 6'b000000, 6'b000010, 0, 1, E_IFR);
        step("srl_id",  0, 6'b000000, 6'b000010, 0, 1, E_ID);
        step("srl_exr", 0, 6'b000000, 6'b000010, 0, 1, E_EXSRL);
        step("srl_rwb", 0, 6'b000000, 6'b000010, 0, 1, E_RWB);
        step("sub_if",  0, 6'b000000, 6'b100010, 0, 1, E_IFR);
        step("sub_id",  0, 6'b000000, 6'b100010, 0, 1, E_ID);
        step("sub_exr", 0, 6'b000000, 6'b100010, 0, 1, E_EXSUB);
        step("sub_rwb", 0, 6'b000000, 6'b100010, 0, 1, E_RWB);
        step("nor_if",  0, 6'b000000, 6'b100111, 0, 1, E_IFR);
        step("nor_id",  0, 6'b000000, 6'b100111, 0, 1, E_ID);
        step("nor_exr", 0, 6'b000000, 6'b100111, 0, 1, E_EXNOR);
        step("nor_rwb", 0, 6'b000000, 6'b100111, 0, 1, E_RWB);
        step("unk_if",  0, 6'b000000, 6'b111111, 0, 1, E_IFR);
        step("unk_id",  0, 6'b000000, 6'b111111, 0, 1, E_ID);
        step("unk_exr", 0, 6'b000000, 6'b111111, 0, 1, E_EXADD);
        step("unk_rwb", 0, 6'b000000, 6'b111111, 0, 1, E_RWB);
        // I-type ALU ops
        step("addi_if", 0, 6'b001000, 6'b000000, 0, 1, E_IFR);
        step("addi_id", 0, 6'b001000, 6'b000000, 0, 1, E_ID);
        step("addi_ex", 0, 6'b001000, 6'b000000, 0, 1, E_EIADD);
        step("addi_wb", 0, 6'b001000, 6'b000000, 0, 1, E_IWB);
        step("andi_if", 0, 6'b001100, 6'b000000, 0, 1, E_IFR);
        step("andi_id", 0, 6'b001100, 6'b000000, 0, 1, E_ID);
        step("andi_ex", 0, 6'b001100, 6'b000000, 0, 1, E_EIAND);
        step("andi_wb", 0, 6'b001100, 6'b000000, 0, 1, E_IWB);
        step("ori_if",  0, 6'b001101, 6'b000000, 0, 1, E_IFR);
        step("ori_id",  0, 6'b001101, 6'b000000, 0, 1, E_ID);
        step("ori_ex",  0, 6'b001101, 6'b000000, 0, 1, E_EIOR);
        step("ori_wb",  0, 6'b001101, 6'b000000, 0, 1, E_IWB);
        step("slti_if", 0, 6'b001010, 6'b000000, 0, 1, E_IFR);
        step("slti_id", 0, 6'b001010, 6'b000000, 0, 1, E_ID);
        step("slti_ex", 0, 6'b001010, 6'b000000, 0, 1, E_EISLT);
        step("slti_wb", 0, 6'b001010, 6'b000000, 0, 1, E_IWB);
        step("end_if",  0, 6'b000000, 6'b000000, 0, 0, E_IFW);

        // Let the monitor drain; a leftover entry counts as a failure.
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
